fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Parametrised fetch stage: owns the PC, issues in-order requests to a handshaked instruction memory
//  and buffers returned {PC, INSTR} pairs in a DEPTH-entry prefetch queue. Drains to decode via valid/ready.
//  Branch redirects from EX (base + displacement) flush the queue and discard in-flight responses.
//  Sits between the PC/IMEM side and the decode stage; successor of the single-register fetch stage.
// PARAMETERS
//  XLEN   32  width of PC, addresses and instruction word
//  DEPTH  4   prefetch queue entries (power of 2, >=2); also max requests in flight
//  ENTRY  0   reset PC / first fetch address
// PORTS
//  clk        in   1     clock, all state updates on posedge
//  rst        in   1     synchronous reset, active-low (0 = reset)
//  PC_R       in   1     redirect request from EX
//  PC_EX      in   XLEN  redirect base address
//  PC_DISP    in   XLEN  redirect displacement
//  IMEM_REQ   out  1     fetch request valid
//  IMEM_ADDR  out  XLEN  fetch address (= current PC)
//  IMEM_GNT   in   1     request accepted this cycle (REQ & GNT = issue)
//  IMEM_RVALID in  1     response valid; responses return in request order
//  IMEM_RDATA in   XLEN  response instruction
//  INSTR_D    out  XLEN  instruction to decode (queue head)
//  PC_DE      out  XLEN  PC of INSTR_D
//  VALID_D    out  1     INSTR_D/PC_DE valid
//  READY_D    in   1     decode accepts (VALID_D & READY_D = pop)
//  Q_CNT      out  clog2(DEPTH)+1  entries currently in queue
// BEHAVIOUR
//  Reset (rst=0 at posedge): PC=ENTRY, queue empty, inflight=0, discard=0. Outputs while/after reset:
//   VALID_D=0, INSTR_D=0, PC_DE=0, Q_CNT=0, IMEM_REQ=0 during reset cycle, IMEM_ADDR=ENTRY. rst beats all.
//  Credits: IMEM_REQ = rst & ~PC_R & (Q_CNT + inflight < DEPTH). Issue => PC <= PC + 4 (mod 2^XLEN),
//   inflight+1. No issue => PC holds. IMEM_ADDR held stable while REQ & ~GNT.
//  Response: IMEM_RVALID => inflight-1. If discard>0: discard-1, data dropped. Else push
//   {PC of matching request, IMEM_RDATA}; PC of each request kept in a DEPTH-deep in-order tag FIFO.
//   RVALID with inflight=0 is a protocol error: ignored, no state change.
//  Queue: circular, registered; head drives INSTR_D/PC_DE combinationally. VALID_D = (Q_CNT!=0).
//   When VALID_D=0, INSTR_D=0 and PC_DE=0. Push and pop in same cycle: Q_CNT unchanged. Full cannot
//   overflow (credit rule). Pointers wrap mod DEPTH.
//  Latency: issue in cycle n, RVALID in cycle m>n => VALID_D in cycle m+1 (one-cycle queue write).
//  Redirect (PC_R=1 at posedge, rst=1): PC <= PC_EX + PC_DISP (mod 2^XLEN, no alignment check);
//   queue cleared (Q_CNT=0, VALID_D=0 next cycle); discard <= inflight after this cycle's response
//   accounting (i.e. all still-outstanding responses dropped); no request issued in PC_R cycle.
//   Pop in redirect cycle is accepted by handshake but flush wins. Back-to-back redirects: last wins,
//   discard recomputed each time as total outstanding. Fetch resumes from target next cycle.
//  Arithmetic: PC, target wrap silently; counters never exceed DEPTH.
// TESTING
//  1 Reset ENTRY=0x100, GNT=1, RVALID 1 cycle after each issue, READY_D=1 -> PC_DE 0x100,0x104,0x108..
//    one per cycle, VALID_D first high 2 cycles after reset release.
//  2 READY_D=0, GNT=1, RVALID=1 -> Q_CNT reaches 4 (DEPTH=4), IMEM_REQ drops once Q_CNT+inflight=4;
//    READY_D=1 for 1 cycle -> exactly one pop, one new request.
//  3 2 requests in flight, PC_R=1, PC_EX=0x200, PC_DISP=0x40 -> both responses dropped,
//    next IMEM_ADDR=0x240, first VALID_D entry has PC_DE=0x240.
//  4 GNT stalled low 3 cycles -> IMEM_ADDR stable, no PC advance; ordering preserved.
//  5 PC_R on consecutive cycles (targets 0x300, 0x400) -> only 0x400 stream reaches decode.
//  6 rst=0 mid-stream with full queue and inflight -> next cycle VALID_D=0, Q_CNT=0, IMEM_ADDR=ENTRY;
//    stray RVALID after reset ignored.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: redirect from EX, instruction-memory handshake and decode-side valid/ready.
// The fetch stage connects through the master modport; its environment connects through the slave modport.
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            PC_R;
    logic [XLEN-1:0] PC_EX;
    logic [XLEN-1:0] PC_DISP;
    logic            IMEM_REQ;
    logic [XLEN-1:0] IMEM_ADDR;
    logic            IMEM_GNT;
    logic            IMEM_RVALID;
    logic [XLEN-1:0] IMEM_RDATA;
    logic [XLEN-1:0] INSTR_D;
    logic [XLEN-1:0] PC_DE;
    logic            VALID_D;
    logic            READY_D;
    logic [CW-1:0]   Q_CNT;

    modport master (
        input  PC_R, PC_EX, PC_DISP, IMEM_GNT, IMEM_RVALID, IMEM_RDATA, READY_D,
        output IMEM_REQ, IMEM_ADDR, INSTR_D, PC_DE, VALID_D, Q_CNT
    );

    modport slave (
        output PC_R, PC_EX, PC_DISP, IMEM_GNT, IMEM_RVALID, IMEM_RDATA, READY_D,
        input  IMEM_REQ, IMEM_ADDR, INSTR_D, PC_DE, VALID_D, Q_CNT
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues in-order IMEM requests under a credit limit and buffers
// {PC, instruction} pairs in a circular prefetch queue; redirects flush and discard in-flight data.
module fetch_queue #(
    parameter int unsigned     XLEN  = 32,
    parameter int unsigned     DEPTH = 4,
    parameter logic [XLEN-1:0] ENTRY = '0
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master fq
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    typedef logic [XLEN-1:0] word_t;

    word_t          pc_q, pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  discard_q, discard_d;
    logic [AW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [AW-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    word_t          q_instr_q [DEPTH];
    word_t          q_instr_d [DEPTH];
    word_t          q_pc_q    [DEPTH];
    word_t          q_pc_d    [DEPTH];
    word_t          tag_q     [DEPTH];
    word_t          tag_d     [DEPTH];

    logic [CW:0]    credit_used;
    logic           req, issue, resp, push, pop, valid;

    always_comb begin
        credit_used = {1'b0, cnt_q} + {1'b0, inflight_q};
        req   = rst & ~fq.PC_R & (credit_used < DEPTH_W);
        issue = req & fq.IMEM_GNT;
        // Responses with nothing outstanding are a protocol error and leave state untouched.
        resp  = fq.IMEM_RVALID & (inflight_q != '0);
        push  = resp & (discard_q == '0);
        valid = (cnt_q != '0);
        pop   = valid & fq.READY_D;

        fq.IMEM_REQ  = req;
        fq.IMEM_ADDR = pc_q;
        fq.VALID_D   = valid;
        fq.INSTR_D   = valid ? q_instr_q[head_q] : '0;
        fq.PC_DE     = valid ? q_pc_q[head_q] : '0;
        fq.Q_CNT     = cnt_q;
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        head_d     = head_q;
        tail_d     = tail_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;
        tag_d      = tag_q;

        // The tag FIFO advances on every response, dropped or not, so it stays aligned with IMEM order.
        if (issue) begin
            pc_d            = pc_q + word_t'(4);
            tag_d[tag_wr_q] = pc_q;
            tag_wr_d        = tag_wr_q + AW'(1);
            inflight_d      = inflight_d + CW'(1);
        end
        if (resp) begin
            tag_rd_d   = tag_rd_q + AW'(1);
            inflight_d = inflight_d - CW'(1);
            if (discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end
        end

        if (fq.PC_R) begin
            // Flush wins over any push/pop this cycle; everything still outstanding gets dropped.
            pc_d      = fq.PC_EX + fq.PC_DISP;
            discard_d = inflight_d;
            cnt_d     = '0;
            head_d    = '0;
            tail_d    = '0;
        end else begin
            if (push) begin
                q_instr_d[tail_q] = fq.IMEM_RDATA;
                q_pc_d[tail_q]    = tag_q[tag_rd_q];
                tail_d            = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CW'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= ENTRY;
            cnt_q      <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            q_instr_q  <= '{default: '0};
            q_pc_q     <= '{default: '0};
            tag_q      <= '{default: '0};
        end else begin
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            q_instr_q  <= q_instr_d;
            q_pc_q     <= q_pc_d;
            tag_q      <= tag_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (XLEN=32, DEPTH=4, ENTRY=0x100) with hand-traced cycle expectations.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

    fetch_queue #(.XLEN(32), .DEPTH(4), .ENTRY(32'h100)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string t, input logic req, input logic [31:0] addr,
                        input logic valid, input logic [31:0] pcde, input logic [2:0] cnt);
        chk($sformatf("%s.req", t),   32'(bus.IMEM_REQ), 32'(req));
        chk($sformatf("%s.addr", t),  bus.IMEM_ADDR,     addr);
        chk($sformatf("%s.valid", t), 32'(bus.VALID_D),  32'(valid));
        chk($sformatf("%s.pcde", t),  bus.PC_DE,         pcde);
        chk($sformatf("%s.cnt", t),   32'(bus.Q_CNT),    32'(cnt));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.PC_R        = 1'b0;
        bus.PC_EX       = '0;
        bus.PC_DISP     = '0;
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b0;
        bus.IMEM_RDATA  = '0;
        bus.READY_D     = 1'b0;
    endtask

    task automatic do_reset(input string t);
        rst = 1'b0;
        idle();
        #1;
        chk($sformatf("%s.rst_req", t), 32'(bus.IMEM_REQ), 32'h0);
        cyc();
        cyc();
        outs($sformatf("%s.rst", t), 1'b0, 32'h100, 1'b0, 32'h0, 3'd0);
        chk($sformatf("%s.rst_instr", t), bus.INSTR_D, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        // Reset values
        do_reset("t0");

        // 1: streaming, one response per cycle, decode always ready
        for (int unsigned k = 0; k < 6; k++) begin
            bus.IMEM_GNT    = 1'b1;
            bus.READY_D     = 1'b1;
            bus.IMEM_RVALID = (k >= 1);
            bus.IMEM_RDATA  = (k >= 1) ? 32'hA000_0100 + 32'(4 * (k - 1)) : 32'h0;
            #1;
            if (k >= 2) begin
                outs($sformatf("t1c%0d", k), 1'b1, 32'h100 + 32'(4 * k), 1'b1,
                     32'h100 + 32'(4 * (k - 2)), 3'd1);
                chk($sformatf("t1c%0d.instr", k), bus.INSTR_D, 32'hA000_0100 + 32'(4 * (k - 2)));
            end else begin
                outs($sformatf("t1c%0d", k), 1'b1, 32'h100 + 32'(4 * k), 1'b0, 32'h0, 3'd0);
            end
            cyc();
        end

        // 2: decode stalled, queue fills to DEPTH and requests stop
        do_reset("t2");
        for (int unsigned k = 0; k < 6; k++) begin
            bus.IMEM_GNT    = 1'b1;
            bus.READY_D     = 1'b0;
            bus.IMEM_RVALID = (k >= 1) && (k <= 4);
            bus.IMEM_RDATA  = (k >= 1) ? 32'hA000_0100 + 32'(4 * (k - 1)) : 32'h0;
            #1;
            outs($sformatf("t2c%0d", k), k < 4, 32'h100 + 32'(4 * ((k < 4) ? k : 4)),
                 k >= 2, (k >= 2) ? 32'h100 : 32'h0, (k < 2) ? 3'd0 : 3'(k - 1));
            cyc();
        end
        bus.IMEM_RVALID = 1'b0;
        bus.READY_D     = 1'b1;
        #1;
        outs("t2c6", 1'b0, 32'h110, 1'b1, 32'h100, 3'd4);
        chk("t2c6.instr", bus.INSTR_D, 32'hA000_0100);
        cyc();
        bus.READY_D = 1'b0;
        #1;
        outs("t2c7", 1'b1, 32'h110, 1'b1, 32'h104, 3'd3);
        cyc();

        // 6: reset mid-stream with 3 queued and 1 in flight, then a stray response
        bus.IMEM_GNT = 1'b0;
        rst = 1'b0;
        #1;
        outs("t6c0", 1'b0, 32'h114, 1'b1, 32'h104, 3'd3);
        cyc();
        outs("t6rst", 1'b0, 32'h100, 1'b0, 32'h0, 3'd0);
        rst = 1'b1;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hBAD0_0BAD;
        bus.READY_D     = 1'b1;
        #1;
        outs("t6c1", 1'b1, 32'h100, 1'b0, 32'h0, 3'd0);
        cyc();
        bus.IMEM_RVALID = 1'b0;
        #1;
        outs("t6c2", 1'b1, 32'h100, 1'b0, 32'h0, 3'd0);
        chk("t6c2.instr", bus.INSTR_D, 32'h0);
        cyc();

        // 3: redirect with two requests in flight; both responses dropped
        do_reset("t3");
        bus.IMEM_GNT = 1'b1;
        bus.READY_D  = 1'b1;
        #1; outs("t3c0", 1'b1, 32'h100, 1'b0, 32'h0, 3'd0); cyc();
        #1; outs("t3c1", 1'b1, 32'h104, 1'b0, 32'h0, 3'd0); cyc();
        bus.PC_R    = 1'b1;
        bus.PC_EX   = 32'h200;
        bus.PC_DISP = 32'h40;
        #1; outs("t3c2", 1'b0, 32'h108, 1'b0, 32'h0, 3'd0); cyc();
        bus.PC_R        = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hDEAD_0100;
        #1; outs("t3c3", 1'b1, 32'h240, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_RDATA = 32'hDEAD_0104;
        #1; outs("t3c4", 1'b1, 32'h244, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_GNT   = 1'b0;
        bus.IMEM_RDATA = 32'hA000_0240;
        #1; outs("t3c5", 1'b1, 32'h248, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_RDATA = 32'hA000_0244;
        #1; outs("t3c6", 1'b1, 32'h248, 1'b1, 32'h240, 3'd1);
        chk("t3c6.instr", bus.INSTR_D, 32'hA000_0240); cyc();
        bus.IMEM_RVALID = 1'b0;
        #1; outs("t3c7", 1'b1, 32'h248, 1'b1, 32'h244, 3'd1);
        chk("t3c7.instr", bus.INSTR_D, 32'hA000_0244); cyc();
        #1; outs("t3c8", 1'b1, 32'h248, 1'b0, 32'h0, 3'd0);

        // 4: grant stalled three cycles; address and PC hold
        do_reset("t4");
        bus.READY_D = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            #1; outs($sformatf("t4c%0d", k), 1'b1, 32'h100, 1'b0, 32'h0, 3'd0); cyc();
        end
        bus.IMEM_GNT = 1'b1;
        #1; outs("t4c3", 1'b1, 32'h100, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hA000_0100;
        #1; outs("t4c4", 1'b1, 32'h104, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_GNT    = 1'b1;
        bus.IMEM_RVALID = 1'b0;
        #1; outs("t4c5", 1'b1, 32'h104, 1'b1, 32'h100, 3'd1);
        chk("t4c5.instr", bus.INSTR_D, 32'hA000_0100); cyc();
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hA000_0104;
        #1; outs("t4c6", 1'b1, 32'h108, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_RVALID = 1'b0;
        #1; outs("t4c7", 1'b1, 32'h108, 1'b1, 32'h104, 3'd1);
        chk("t4c7.instr", bus.INSTR_D, 32'hA000_0104); cyc();

        // 5: back-to-back redirects (0x300 then 0x500+0xFFFFFF00 wraps to 0x400)
        do_reset("t5");
        bus.IMEM_GNT = 1'b1;
        bus.READY_D  = 1'b1;
        #1; outs("t5c0", 1'b1, 32'h100, 1'b0, 32'h0, 3'd0); cyc();
        bus.PC_R        = 1'b1;
        bus.PC_EX       = 32'h300;
        bus.PC_DISP     = 32'h0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hA000_0100;
        #1; outs("t5c1", 1'b0, 32'h104, 1'b0, 32'h0, 3'd0); cyc();
        bus.PC_EX       = 32'h500;
        bus.PC_DISP     = 32'hFFFF_FF00;
        bus.IMEM_RVALID = 1'b0;
        #1; outs("t5c2", 1'b0, 32'h300, 1'b0, 32'h0, 3'd0); cyc();
        bus.PC_R = 1'b0;
        #1; outs("t5c3", 1'b1, 32'h400, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hA000_0400;
        #1; outs("t5c4", 1'b1, 32'h404, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b0;
        #1; outs("t5c5", 1'b1, 32'h408, 1'b1, 32'h400, 3'd1);
        chk("t5c5.instr", bus.INSTR_D, 32'hA000_0400); cyc();
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hA000_0404;
        #1; outs("t5c6", 1'b1, 32'h408, 1'b0, 32'h0, 3'd0); cyc();
        bus.IMEM_RVALID = 1'b0;
        #1; outs("t5c7", 1'b1, 32'h408, 1'b1, 32'h404, 3'd1);
        chk("t5c7.instr", bus.INSTR_D, 32'hA000_0404); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
